// File: rtl/alu_immediate_if.sv
// Decoder/regfile/ALU control bundle for the register-immediate sequencer.
// master: the sequencer (alu_immediate); slave: the decoder/datapath side.
interface alu_immediate_if;
  logic        FSM_start;
  logic [3:0]  opcode;
  logic [5:0]  param1;
  logic [15:0] immediate;
  logic        bus_register_input_en;
  logic        bus_register_out_en;
  logic [5:0]  register_addr;
  logic        latched_bus1_en;
  logic        latched_bus2_en;
  logic        alu_bus_out_en;
  logic [3:0]  alu_control;
  logic        immediate_en;
  logic        done;
  logic [15:0] FSM_bus_output;

  modport master (
    input  FSM_start, opcode, param1, immediate,
    output bus_register_input_en, bus_register_out_en, register_addr,
           latched_bus1_en, latched_bus2_en, alu_bus_out_en, alu_control,
           immediate_en, done, FSM_bus_output
  );

  modport slave (
    output FSM_start, opcode, param1, immediate,
    input  bus_register_input_en, bus_register_out_en, register_addr,
           latched_bus1_en, latched_bus2_en, alu_bus_out_en, alu_control,
           immediate_en, done, FSM_bus_output
  );
endinterface

// File: rtl/alu_immediate.sv
// Sequencer for one Rd <- Rd op imm instruction over the shared 16-bit bus.
// Define ALU_IMM_CMP_NOWB_EN to make opcode 4'hF compare-only (no writeback).
//
// state  | meaning
// IDLE   | waiting for FSM_start, all outputs low
// LOAD_A | regfile drives Rd onto bus, ALU operand A latches
// LOAD_B | immediate driven onto bus, ALU operand B latches
// EXEC   | ALU drives result, regfile writes it back into Rd
// DONE   | one-cycle completion pulse
module alu_immediate (
  input  logic            clock,
  input  logic            reset,
  alu_immediate_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  opcode_q;
  logic [5:0]  param1_q;
  logic [15:0] immediate_q;
  logic        writeback;

`ifdef ALU_IMM_CMP_NOWB_EN
  assign writeback = (opcode_q != 4'hF);
`else
  assign writeback = 1'b1;
`endif

  // Outputs are registered alongside the next state, so each is valid for
  // exactly the cycle the FSM spends in the state that owns it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                     <= IDLE;
      opcode_q                  <= 4'h0;
      param1_q                  <= 6'h00;
      immediate_q               <= 16'h0000;
      bus.bus_register_input_en <= 1'b0;
      bus.bus_register_out_en   <= 1'b0;
      bus.register_addr         <= 6'h00;
      bus.latched_bus1_en       <= 1'b0;
      bus.latched_bus2_en       <= 1'b0;
      bus.alu_bus_out_en        <= 1'b0;
      bus.alu_control           <= 4'h0;
      bus.immediate_en          <= 1'b0;
      bus.done                  <= 1'b0;
      bus.FSM_bus_output        <= 16'h0000;
    end else begin
      bus.bus_register_input_en <= 1'b0;
      bus.bus_register_out_en   <= 1'b0;
      bus.register_addr         <= 6'h00;
      bus.latched_bus1_en       <= 1'b0;
      bus.latched_bus2_en       <= 1'b0;
      bus.alu_bus_out_en        <= 1'b0;
      bus.alu_control           <= 4'h0;
      bus.immediate_en          <= 1'b0;
      bus.done                  <= 1'b0;
      bus.FSM_bus_output        <= 16'h0000;
      case (state)
        IDLE: begin
          if (bus.FSM_start) begin
            opcode_q                <= bus.opcode;
            param1_q                <= bus.param1;
            immediate_q             <= bus.immediate;
            state                   <= LOAD_A;
            bus.bus_register_out_en <= 1'b1;
            bus.latched_bus1_en     <= 1'b1;
            bus.register_addr       <= bus.param1;
            bus.alu_control         <= bus.opcode;
          end
        end
        LOAD_A: begin
          state               <= LOAD_B;
          bus.immediate_en    <= 1'b1;
          bus.FSM_bus_output  <= immediate_q;
          bus.latched_bus2_en <= 1'b1;
          bus.alu_control     <= opcode_q;
        end
        LOAD_B: begin
          state                     <= EXEC;
          bus.alu_bus_out_en        <= 1'b1;
          bus.bus_register_input_en <= writeback;
          bus.register_addr         <= param1_q;
          bus.alu_control           <= opcode_q;
        end
        EXEC: begin
          state    <= DONE;
          bus.done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_immediate.sv
// Directed-vector bench for alu_immediate: every output is packed into one
// vector and compared against a hand-built expectation per cycle.
module tb_alu_immediate;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;
  int   done_tick [2];
  int   n_done;

  alu_immediate_if bus_if ();

  alu_immediate dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {reg_in, reg_out, addr[6], lat1, lat2, alu_out, alu_ctrl[4], imm_en, done, bus[16]}
  logic [32:0] obs;
  assign obs = {bus_if.bus_register_input_en, bus_if.bus_register_out_en,
                bus_if.register_addr, bus_if.latched_bus1_en,
                bus_if.latched_bus2_en, bus_if.alu_bus_out_en,
                bus_if.alu_control, bus_if.immediate_en, bus_if.done,
                bus_if.FSM_bus_output};

  // phase: 0 idle, 1 load_a, 2 load_b, 3 exec, 4 done
  function automatic logic [32:0] exp_v(int ph, logic [3:0] op, logic [5:0] a,
                                        logic [15:0] imm, logic wb);
    logic [32:0] v;
    v = 33'd0;
    case (ph)
      1: v = {1'b0, 1'b1, a, 1'b1, 1'b0, 1'b0, op, 1'b0, 1'b0, 16'h0000};
      2: v = {1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, op, 1'b1, 1'b0, imm};
      3: v = {wb, 1'b0, a, 1'b0, 1'b0, 1'b1, op, 1'b0, 1'b0, 16'h0000};
      4: v = {1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000};
      default: v = 33'd0;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [32:0] e);
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // One full operation; optionally scrambles the inputs during LOAD_B.
  task automatic run_op(string tag, logic [3:0] op, logic [5:0] a,
                        logic [15:0] imm, logic wb, bit scramble);
    bus_if.FSM_start = 1'b1;
    bus_if.opcode    = op;
    bus_if.param1    = a;
    bus_if.immediate = imm;
    tick();
    bus_if.FSM_start = 1'b0;
    chk({tag, "_load_a"}, exp_v(1, op, a, imm, wb));
    tick();
    chk({tag, "_load_b"}, exp_v(2, op, a, imm, wb));
    if (scramble) begin
      bus_if.opcode    = 4'h7;
      bus_if.param1    = 6'd5;
      bus_if.immediate = 16'hBEEF;
    end
    tick();
    chk({tag, "_exec"}, exp_v(3, op, a, imm, wb));
    tick();
    chk({tag, "_done"}, exp_v(4, op, a, imm, wb));
    tick();
    chk({tag, "_idle"}, exp_v(0, op, a, imm, wb));
  endtask

  initial begin
    logic        wb_f;
    int          ph_seq [10];
    n_vec  = 0;
    n_err  = 0;
    n_done = 0;
    reset            = 1'b0;
    bus_if.FSM_start = 1'b0;
    bus_if.opcode    = 4'h0;
    bus_if.param1    = 6'd0;
    bus_if.immediate = 16'h0000;

    #1;
    chk("reset_state", 33'd0);
    tick();
    tick();
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_quiet", 33'd0);
    end

    run_op("op1", 4'h1, 6'd1, 16'h1234, 1'b1, 1'b1);
    run_op("opA_r63", 4'hA, 6'd63, 16'hFFFF, 1'b1, 1'b0);
    run_op("op0_r0", 4'h0, 6'd0, 16'h8001, 1'b1, 1'b0);

`ifdef ALU_IMM_CMP_NOWB_EN
    wb_f = 1'b0;
`else
    wb_f = 1'b1;
`endif
    run_op("opF", 4'hF, 6'd2, 16'h5555, wb_f, 1'b0);

    // Start held high: second accept only after DONE -> IDLE.
    ph_seq = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    bus_if.FSM_start = 1'b1;
    bus_if.opcode    = 4'h2;
    bus_if.param1    = 6'd3;
    bus_if.immediate = 16'h00AA;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 8) bus_if.FSM_start = 1'b0;
      chk("held_start", exp_v(ph_seq[i], 4'h2, 6'd3, 16'h00AA, 1'b1));
      if (bus_if.done === 1'b1 && n_done < 2) begin
        done_tick[n_done] = i;
        n_done++;
      end
    end
    n_vec++;
    assert (n_done == 2 && done_tick[1] - done_tick[0] == 5) else begin
      n_err++;
      $error("FAIL done_interval observed=%0d pulses gap %0d expected=2 pulses gap 5",
             n_done, done_tick[1] - done_tick[0]);
    end

    // Abort mid-EXEC.
    bus_if.FSM_start = 1'b1;
    bus_if.opcode    = 4'h6;
    bus_if.param1    = 6'd9;
    bus_if.immediate = 16'h0F0F;
    tick();
    bus_if.FSM_start = 1'b0;
    tick();
    tick();
    chk("pre_abort_exec", exp_v(3, 4'h6, 6'd9, 16'h0F0F, 1'b1));
    #2;
    reset = 1'b0;
    #1;
    chk("abort_async", 33'd0);
    tick();
    chk("abort_held", 33'd0);
    #3;
    reset = 1'b1;
    tick();
    chk("abort_release_idle", 33'd0);
    run_op("post_abort", 4'h3, 6'd12, 16'hC3C3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
